// File: rtl/systolic_skew_feeder.sv
// rtl/systolic_skew_feeder.sv - skewing left-edge feeder for a systolic array (optional stall: FEEDER_STALL_EN)
module systolic_skew_feeder #(
    parameter int N  = 4,
    parameter int DW = 8
) (
    input  logic            clk,
    input  logic            rst,
`ifdef FEEDER_STALL_EN
    input  logic            stall,
`endif
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [N*DW-1:0] in_data,
    input  logic            in_last,
    output logic [N*DW-1:0] edge_data,
    output logic [N-1:0]    edge_vld,
    output logic            busy,
    output logic            done
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_STREAM = 2'd1;
    localparam logic [1:0] S_DRAIN  = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    localparam int            CW           = $clog2(N) + 1;
    localparam logic [CW-1:0] DRAIN_LEN    = CW'(N - 1);
    localparam logic          LAST_TO_DONE = (N == 1);

    logic [1:0]    r_state;
    logic [CW-1:0] r_cnt;
    logic          w_run;
    logic          w_accept;
    logic [1:0]    w_after_last;

`ifdef FEEDER_STALL_EN
    assign w_run = ~stall;
`else
    assign w_run = 1'b1;
`endif

    assign in_ready     = w_run && ((r_state == S_IDLE) || (r_state == S_STREAM));
    assign w_accept     = in_valid && in_ready;
    assign busy         = (r_state != S_IDLE);
    // A stalled DONE holds its state, so the pulse fires once the stall lifts.
    assign done         = w_run && (r_state == S_DONE);
    // With a single row the last vector is already on every lane one cycle later.
    assign w_after_last = LAST_TO_DONE ? S_DONE : S_DRAIN;

    // Tile FSM and drain counter; everything freezes while not running.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else if (w_run) begin
            case (r_state)
                S_IDLE, S_STREAM: begin
                    if (w_accept) begin
                        if (in_last) begin
                            r_state <= w_after_last;
                            r_cnt   <= DRAIN_LEN;
                        end else begin
                            r_state <= S_STREAM;
                        end
                    end
                end
                S_DRAIN: begin
                    if (r_cnt <= CW'(1)) begin
                        r_state <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    for (genvar gi = 0; gi < N; gi++) begin : g_lane
        logic [DW-1:0] r_dpipe [0:gi];
        logic          r_vpipe [0:gi];

        // Lane gi delay line of depth gi+1; non-accept cycles inject zero fill.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                for (int j = 0; j <= gi; j++) begin
                    r_dpipe[j] <= '0;
                    r_vpipe[j] <= 1'b0;
                end
            end else if (w_run) begin
                r_dpipe[0] <= w_accept ? in_data[gi*DW +: DW] : '0;
                r_vpipe[0] <= w_accept;
                for (int j = 1; j <= gi; j++) begin
                    r_dpipe[j] <= r_dpipe[j-1];
                    r_vpipe[j] <= r_vpipe[j-1];
                end
            end
        end

        assign edge_data[gi*DW +: DW] = r_dpipe[gi];
        assign edge_vld[gi]           = r_vpipe[gi] && w_run;
    end

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// tb/tb_systolic_skew_feeder.sv - directed self-checking bench for systolic_skew_feeder
module tb_systolic_skew_feeder;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        in_last;
    logic [31:0] edge_data;
    logic [3:0]  edge_vld;
    logic        busy;
    logic        done;
`ifdef FEEDER_STALL_EN
    logic        stall;
    initial stall = 1'b0;
`endif

    systolic_skew_feeder #(.N(4), .DW(8)) u_dut (
        .clk       (clk),
        .rst       (rst),
`ifdef FEEDER_STALL_EN
        .stall     (stall),
`endif
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .edge_data (edge_data),
        .edge_vld  (edge_vld),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [31:0] rec_data [0:15];
    logic [3:0]  rec_vld  [0:15];
    logic        rec_done [0:15];
    logic        rec_rdy  [0:15];
    logic        rec_busy [0:15];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Record this cycle's outputs, then drive this cycle's inputs.
    task automatic drive(input logic v, input logic [31:0] d, input logic l);
        @(negedge clk);
        if (cyc < 16) begin
            rec_data[cyc] = edge_data;
            rec_vld[cyc]  = edge_vld;
            rec_done[cyc] = done;
            rec_rdy[cyc]  = in_ready;
            rec_busy[cyc] = busy;
        end
        in_valid = v;
        in_data  = d;
        in_last  = l;
        cyc++;
    endtask

    function automatic logic [31:0] ln(input int c, input int i);
        return {24'd0, rec_data[c][i*8 +: 8]};
    endfunction

    function automatic logic [31:0] lv(input int c, input int i);
        return {31'd0, rec_vld[c][i]};
    endfunction

    initial begin
        rst      = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        in_last  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_data",  edge_data, 32'h0);
        chk("rst_vld",   {28'd0, edge_vld}, 32'h0);
        chk("rst_busy",  {31'd0, busy}, 32'h0);
        chk("rst_done",  {31'd0, done}, 32'h0);
        chk("rst_ready", {31'd0, in_ready}, 32'h1);
        @(negedge clk);
        rst = 1'b1;

        // Single two-vector tile
        cyc = 0;
        drive(1'b1, 32'h04030201, 1'b0);
        drive(1'b1, 32'h08070605, 1'b1);
        repeat (6) drive(1'b0, 32'h0, 1'b0);
        chk("t1_l0_c1",   ln(1, 0), 32'h01);
        chk("t1_l0v_c1",  lv(1, 0), 32'h1);
        chk("t1_l0_c2",   ln(2, 0), 32'h05);
        chk("t1_l0v_c3",  lv(3, 0), 32'h0);
        chk("t1_l1_c2",   ln(2, 1), 32'h02);
        chk("t1_l1_c3",   ln(3, 1), 32'h06);
        chk("t1_l3v_c3",  lv(3, 3), 32'h0);
        chk("t1_l3_c4",   ln(4, 3), 32'h04);
        chk("t1_l3_c5",   ln(5, 3), 32'h08);
        chk("t1_l3v_c5",  lv(5, 3), 32'h1);
        chk("t1_done_c4", {31'd0, rec_done[4]}, 32'h0);
        chk("t1_done_c5", {31'd0, rec_done[5]}, 32'h1);
        chk("t1_done_c6", {31'd0, rec_done[6]}, 32'h0);
        chk("t1_rdy_c1",  {31'd0, rec_rdy[1]}, 32'h1);
        for (int c = 2; c <= 5; c++) chk($sformatf("t1_rdy_c%0d", c), {31'd0, rec_rdy[c]}, 32'h0);
        chk("t1_rdy_c6",  {31'd0, rec_rdy[6]}, 32'h1);
        chk("t1_busy_c6", {31'd0, rec_busy[6]}, 32'h0);

        // Bubble between two vectors
        cyc = 0;
        drive(1'b1, 32'h14131211, 1'b0);
        drive(1'b0, 32'hDEADBEEF, 1'b1);
        drive(1'b1, 32'h18171615, 1'b1);
        repeat (6) drive(1'b0, 32'h0, 1'b0);
        chk("bb_l0_c1",   ln(1, 0), 32'h11);
        chk("bb_l0_c2",   ln(2, 0), 32'h00);
        chk("bb_l0v_c2",  lv(2, 0), 32'h0);
        chk("bb_l0_c3",   ln(3, 0), 32'h15);
        chk("bb_l2_c3",   ln(3, 2), 32'h13);
        chk("bb_l2v_c4",  lv(4, 2), 32'h0);
        chk("bb_l2_c5",   ln(5, 2), 32'h17);
        chk("bb_l3_c4",   ln(4, 3), 32'h14);
        chk("bb_l3_c5",   ln(5, 3), 32'h00);
        chk("bb_l3v_c5",  lv(5, 3), 32'h0);
        chk("bb_l3_c6",   ln(6, 3), 32'h18);
        chk("bb_busy_c2", {31'd0, rec_busy[2]}, 32'h1);
        chk("bb_done_c6", {31'd0, rec_done[6]}, 32'h1);

        // Single-vector tile
        cyc = 0;
        drive(1'b1, 32'hAABBCCDD, 1'b1);
        repeat (6) drive(1'b0, 32'h0, 1'b0);
        chk("sv_l0_c1",   ln(1, 0), 32'hDD);
        chk("sv_l3_c4",   ln(4, 3), 32'hAA);
        chk("sv_rdy_c1",  {31'd0, rec_rdy[1]}, 32'h0);
        chk("sv_busy_c1", {31'd0, rec_busy[1]}, 32'h1);
        chk("sv_done_c3", {31'd0, rec_done[3]}, 32'h0);
        chk("sv_done_c4", {31'd0, rec_done[4]}, 32'h1);
        chk("sv_rdy_c5",  {31'd0, rec_rdy[5]}, 32'h1);

        // Back-to-back tiles with in_valid held high
        cyc = 0;
        drive(1'b1, 32'h34333231, 1'b0);
        drive(1'b1, 32'h38373635, 1'b1);
        repeat (5) drive(1'b1, 32'h5C5B5A59, 1'b1);
        repeat (7) drive(1'b0, 32'h0, 1'b0);
        chk("b2b_done_c5", {31'd0, rec_done[5]}, 32'h1);
        chk("b2b_rdy_c5",  {31'd0, rec_rdy[5]}, 32'h0);
        chk("b2b_rdy_c6",  {31'd0, rec_rdy[6]}, 32'h1);
        chk("b2b_rdy_c7",  {31'd0, rec_rdy[7]}, 32'h0);
        chk("b2b_l3_c5",   ln(5, 3), 32'h38);
        chk("b2b_l0v_c6",  lv(6, 0), 32'h0);
        chk("b2b_l0_c7",   ln(7, 0), 32'h59);
        chk("b2b_l3_c6",   ln(6, 3), 32'h00);
        chk("b2b_l3v_c9",  lv(9, 3), 32'h0);
        chk("b2b_l3_c10",  ln(10, 3), 32'h5C);
        chk("b2b_done_c9", {31'd0, rec_done[9]}, 32'h0);
        chk("b2b_done_c10",{31'd0, rec_done[10]}, 32'h1);

        // Asynchronous reset in the middle of a stream
        cyc = 0;
        repeat (3) drive(1'b1, 32'h44434241, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        chk("ar_busy_pre", {31'd0, busy}, 32'h1);
        chk("ar_vld_pre",  {28'd0, edge_vld}, 32'h7);
        #2;
        rst = 1'b0;
        #1;
        chk("ar_data",  edge_data, 32'h0);
        chk("ar_vld",   {28'd0, edge_vld}, 32'h0);
        chk("ar_busy",  {31'd0, busy}, 32'h0);
        chk("ar_ready", {31'd0, in_ready}, 32'h1);
        @(negedge clk);
        rst = 1'b1;
        cyc = 0;
        repeat (5) drive(1'b0, 32'h0, 1'b0);
        for (int c = 1; c <= 4; c++) chk($sformatf("ar_flush_c%0d", c), {28'd0, rec_vld[c]}, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
